sdrd_deser: RTL and testbench

SDRD_DESER -- requirements
Module: sdrd_deser

---
 rtl/sdrd_pkg.sv | 26 ++
 rtl/sdrd_fifo.sv | 55 +++++
 rtl/sdrd_deser.sv | 134 +++++++++++++
 tb/tb_sdrd_deser.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sdrd_pkg.sv
// Shared constants and types for the serial-readback deserializer: bus window,
// register offsets, STATUS layout and the bit-assembly FSM states.
package sdrd_pkg;

  localparam logic [1:0] WIN_BA_HI  = 2'b01;  // ba[13:12] of the serial section
  localparam logic [3:0] REG_DATA   = 4'h2;
  localparam logic [3:0] REG_STATUS = 4'h3;

  localparam int STAT_OVF_BIT = 7;
  localparam int STAT_ERR_BIT = 6;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  function automatic logic [7:0] pack_status(input logic ovf, input logic err,
                                             input logic [3:0] cnt);
    logic [7:0] s;
    s               = {4'h0, cnt};
    s[STAT_OVF_BIT] = ovf;
    s[STAT_ERR_BIT] = err;
    return s;
  endfunction

endpackage

// File: rtl/sdrd_fifo.sv
// Small byte FIFO with first-word-fall-through head. A pop on an empty FIFO is
// ignored; a push on a full FIFO lands only when a pop frees a slot that cycle.
module sdrd_fifo #(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    // DEPTH is a power of two, so plain pointer overflow is the modulo wrap
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sdrd_deser.sv
// Serial readback deserializer: assembles MSB-first bytes from the sequencer
// bit stream into a FIFO and exposes DATA/STATUS registers on the host bus.
module sdrd_deser
  import sdrd_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sser_n,
  input  logic [9:0] ba,
  input  logic       br_w,
  input  logic       sdrd,
  input  logic       bit_vld,
  input  logic       frm_start,
  output logic [7:0] rd_data,
  output logic       rd_oe,
  output logic       irq
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          acc_q;

  logic          acc, is_data, is_stat, data_first, stat_first;
  logic          push, pop, full, empty;
  logic [7:0]    push_byte, head;
  logic [CW-1:0] count;
  logic [3:0]    count4;
  logic          unused_ba;

  // ba is bus address bits [13:4]; bits [11:8] play no part in the decode
  assign acc        = !sser_n && (ba[9:8] == WIN_BA_HI) && br_w;
  assign is_data    = (ba[3:0] == REG_DATA);
  assign is_stat    = (ba[3:0] == REG_STATUS);
  assign data_first = acc && !acc_q && is_data;
  assign stat_first = acc && !acc_q && is_stat;
  assign pop        = data_first;
  assign unused_ba  = ^ba[7:4];
  assign count4     = 4'(count);

  assign rd_oe = acc && (is_data || is_stat);
  assign irq   = !empty || err_q;

  always_comb begin
    rd_data = 8'h00;
    if (acc && is_data && !empty) rd_data = head;
    else if (acc && is_stat)      rd_data = pack_status(ovf_q, err_q, count4);
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    idle_d    = idle_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    push      = 1'b0;
    push_byte = {shreg_q[6:0], sdrd};

    if (stat_first) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end

    if (frm_start) begin
      // a new frame always restarts assembly; a coincident bit is its first bit
      state_d  = ST_SHIFT;
      idle_d   = '0;
      shreg_d  = bit_vld ? {7'b0, sdrd} : 8'h00;
      bitcnt_d = bit_vld ? 3'd1 : 3'd0;
    end else if (state_q == ST_SHIFT) begin
      if (bit_vld) begin
        shreg_d  = push_byte;
        bitcnt_d = bitcnt_q + 3'd1;
        idle_d   = '0;
        push     = (bitcnt_q == 3'd7);
      end else if (bitcnt_q != 3'd0) begin
        if (idle_q == TW'(TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          bitcnt_d = 3'd0;
          shreg_d  = 8'h00;
          idle_d   = '0;
          err_d    = 1'b1;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
    end

    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'h00;
      idle_q   <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      idle_q   <= idle_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      acc_q    <= acc;
    end
  end

  sdrd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_byte),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_sdrd_deser.sv
// Directed bench for sdrd_deser: bit assembly, FIFO full/overflow, timeout,
// access edge behaviour and asynchronous reset, with hand-computed expectations.
module tb_sdrd_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sser_n = 1'b1;
  logic [9:0] ba = 10'h000;
  logic       br_w = 1'b0;
  logic       sdrd = 1'b0;
  logic       bit_vld = 1'b0;
  logic       frm_start = 1'b0;
  logic [7:0] rd_data;
  logic       rd_oe;
  logic       irq;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  sdrd_deser #(.DEPTH(2), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sser_n    (sser_n),
    .ba        (ba),
    .br_w      (br_w),
    .sdrd      (sdrd),
    .bit_vld   (bit_vld),
    .frm_start (frm_start),
    .rd_data   (rd_data),
    .rd_oe     (rd_oe),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic start, input logic b);
    frm_start = start;
    bit_vld   = 1'b1;
    sdrd      = b;
    tick();
    frm_start = 1'b0;
    bit_vld   = 1'b0;
    sdrd      = 1'b0;
  endtask

  task automatic send_byte(input logic start, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive_bit(start && (i == 7), v[i]);
  endtask

  task automatic bus_set(input logic [3:0] sel);
    sser_n = 1'b0;
    br_w   = 1'b1;
    ba     = {2'b01, 4'h0, sel};
  endtask

  task automatic bus_clear();
    sser_n = 1'b1;
    br_w   = 1'b0;
    ba     = 10'h000;
  endtask

  // one-cycle access followed by one idle bus cycle so the next access is fresh
  task automatic bus_read(input string tag, input logic [3:0] sel, input logic [7:0] exp);
    bus_set(sel);
    #1;
    check({tag, "_oe"}, 32'(rd_oe), 32'd1);
    check(tag, 32'(rd_data), 32'(exp));
    tick();
    bus_clear();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #1;
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_oe_idle", 32'(rd_oe), 32'd0);
    bus_set(4'h3);
    #1;
    check("rst_status", 32'(rd_data), 32'h00);
    bus_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // frm_start alone, then 0xA5 bit by bit
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
    send_byte(1'b0, 8'hA5);
    check("a5_irq", 32'(irq), 32'd1);
    bus_read("a5_status", 4'h3, 8'h01);
    bus_read("a5_data", 4'h2, 8'hA5);
    check("a5_irq_after_pop", 32'(irq), 32'd0);

    // overflow with DEPTH=2
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    send_byte(1'b0, 8'h33);
    bus_read("ovf_status", 4'h3, 8'h82);
    bus_read("ovf_data0", 4'h2, 8'h11);
    bus_read("ovf_data1", 4'h2, 8'h22);
    bus_read("ovf_status2", 4'h3, 8'h00);
    check("ovf_irq_empty", 32'(irq), 32'd0);

    // idle timeout after 3 bits
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    repeat (63) tick();
    check("to_before", 32'(irq), 32'd0);
    tick();
    check("to_irq", 32'(irq), 32'd1);
    send_byte(1'b0, 8'hFF);
    bus_read("to_status", 4'h3, 8'h40);
    check("to_irq_cleared", 32'(irq), 32'd0);

    // frm_start mid-byte discards, then push and pop meet on a full FIFO
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    send_byte(1'b1, 8'h66);
    send_byte(1'b0, 8'h77);
    for (int i = 7; i >= 1; i--) drive_bit(1'b0, (8'h5A >> i) & 8'h01);
    bit_vld = 1'b1;
    sdrd    = 1'b0;
    bus_set(4'h2);
    #1;
    check("pp_head", 32'(rd_data), 32'h66);
    tick();
    bit_vld = 1'b0;
    bus_clear();
    tick();
    bus_read("pp_status", 4'h3, 8'h02);
    bus_read("pp_data0", 4'h2, 8'h77);
    bus_read("pp_data1", 4'h2, 8'h5A);

    // held access pops once; out-of-map accesses do nothing
    send_byte(1'b0, 8'hC3);
    send_byte(1'b0, 8'h3C);
    bus_set(4'h2);
    #1;
    check("hold_first", 32'(rd_data), 32'hC3);
    repeat (4) tick();
    check("hold_last", 32'(rd_data), 32'h3C);
    tick();
    bus_clear();
    tick();
    bus_read("hold_status", 4'h3, 8'h01);
    bus_set(4'h4);
    #1;
    check("sel4_oe", 32'(rd_oe), 32'd0);
    check("sel4_data", 32'(rd_data), 32'h00);
    tick();
    bus_clear();
    tick();
    bus_set(4'h2);
    sser_n = 1'b1;
    #1;
    check("nosel_oe", 32'(rd_oe), 32'd0);
    tick();
    bus_clear();
    tick();
    bus_read("nopop_status", 4'h3, 8'h01);
    bus_read("nopop_data", 4'h2, 8'h3C);

    // asynchronous reset mid-byte
    send_byte(1'b0, 8'h99);
    check("rst_pre_irq", 32'(irq), 32'd1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_irq", 32'(irq), 32'd0);
    bus_set(4'h2);
    #1;
    check("arst_data", 32'(rd_data), 32'h00);
    bus_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    send_byte(1'b0, 8'hE7);
    bus_read("arst_status", 4'h3, 8'h00);
    check("arst_irq_after", 32'(irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
